// File: rtl/opb_master_bridge_pkg.sv
// Shared types and constants for the OPB master bridge.
package opb_pkg;

   // Bridge sequencing states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_REQ     = 3'd1,
      ST_XFER    = 3'd2,
      ST_BACKOFF = 3'd3,
      ST_RESP    = 3'd4
   } state_t;

   // Response codes returned on rsp_code
   localparam logic [1:0] RSP_OK        = 2'd0;
   localparam logic [1:0] RSP_ERRACK    = 2'd1;
   localparam logic [1:0] RSP_TIMEOUT   = 2'd2;
   localparam logic [1:0] RSP_RETRY_EXH = 2'd3;

   // Bit reversal for callers that hold an OPB vector with bus bit 0 at
   // index 0 and need it in [MSB:0] order (bus bit 0 = MSB).
   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/opb_master_bridge.sv
// OPB single-beat bus master: takes a local cmd, arbitrates for the bus,
// runs one transfer (with retry, error-ack and timeout handling) and
// returns a rsp. Bus vectors are declared [N-1:0]; OPB bit 0 is the MSB,
// so index N-1 carries OPB bit 0 and values pass straight through.
module opb_master_bridge
   import opb_pkg::*;
#(
   parameter int C_OPB_AWIDTH  = 32,
   parameter int C_OPB_DWIDTH  = 32,
   parameter int C_TOUT_CYCLES = 16,
   parameter int C_MAX_RETRY   = 8
) (
   input  logic                      OPB_Clk,
   input  logic                      OPB_Rst_n,
   // local command side
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic                      cmd_rnw,
   input  logic [C_OPB_AWIDTH-1:0]   cmd_addr,
   input  logic [C_OPB_DWIDTH/8-1:0] cmd_be,
   input  logic [C_OPB_DWIDTH-1:0]   cmd_wdata,
   // local response side
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
   output logic                      rsp_err,
   output logic [1:0]                rsp_code,
   // OPB master side
   output logic                      M_request,
   input  logic                      OPB_MGrant,
   output logic                      M_select,
   output logic                      M_RNW,
   output logic                      M_seqAddr,
   output logic [C_OPB_AWIDTH-1:0]   M_ABus,
   output logic [C_OPB_DWIDTH/8-1:0] M_BE,
   output logic [C_OPB_DWIDTH-1:0]   M_DBus,
   input  logic [C_OPB_DWIDTH-1:0]   OPB_DBus,
   input  logic                      OPB_xferAck,
   input  logic                      OPB_errAck,
   input  logic                      OPB_retry,
   input  logic                      OPB_toutSup
);

   localparam int BEW = C_OPB_DWIDTH / 8;
   localparam int TW  = $clog2(C_TOUT_CYCLES + 1);
   localparam int RW  = $clog2(C_MAX_RETRY + 1);

   localparam logic [TW-1:0] TOUT_LAST  = TW'(C_TOUT_CYCLES - 1);
   localparam logic [TW-1:0] TOUT_MAX   = TW'(C_TOUT_CYCLES);
   localparam logic [RW-1:0] RETRY_LAST = RW'(C_MAX_RETRY - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(C_MAX_RETRY);

   state_t                    r_state;
   state_t                    w_next;

   logic                      r_rnw;
   logic [C_OPB_AWIDTH-1:0]   r_addr;
   logic [BEW-1:0]            r_be;
   logic [C_OPB_DWIDTH-1:0]   r_wdata;
   logic [TW-1:0]             r_tout_cnt;
   logic [RW-1:0]             r_retry_cnt;
   logic [C_OPB_DWIDTH-1:0]   r_rsp_rdata;
   logic                      r_rsp_err;
   logic [1:0]                r_rsp_code;

   logic                      w_in_xfer;
   logic                      w_ev_err;
   logic                      w_ev_ack;
   logic                      w_ev_retry;
   logic                      w_ev_tout;
   logic                      w_retry_exh;

   // Slave responses resolved by priority: errAck > xferAck > retry > timeout.
   // The timeout fires on the cycle the counter would reach its limit.
   assign w_in_xfer   = (r_state == ST_XFER);
   assign w_ev_err    = w_in_xfer & OPB_errAck;
   assign w_ev_ack    = w_in_xfer & OPB_xferAck & ~OPB_errAck;
   assign w_ev_retry  = w_in_xfer & OPB_retry & ~OPB_xferAck & ~OPB_errAck;
   assign w_ev_tout   = w_in_xfer & ~OPB_retry & ~OPB_xferAck & ~OPB_errAck &
                        ~OPB_toutSup & (r_tout_cnt >= TOUT_LAST);
   assign w_retry_exh = (r_retry_cnt >= RETRY_LAST);

   // Bus drive: everything parks at zero outside the transfer phase
   assign M_RNW     = w_in_xfer & r_rnw;
   assign M_seqAddr = 1'b0;
   assign M_ABus    = w_in_xfer ? r_addr : '0;
   assign M_BE      = w_in_xfer ? r_be : '0;
   assign M_DBus    = (w_in_xfer && !r_rnw) ? r_wdata : '0;

   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign rsp_code  = r_rsp_code;

   // State register
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) r_state <= ST_IDLE;
      else            r_state <= w_next;
   end

   // Next-state and handshake/arbitration outputs
   always_comb begin
      w_next    = r_state;
      cmd_ready = 1'b0;
      M_request = 1'b0;
      M_select  = 1'b0;
      rsp_valid = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) w_next = ST_REQ;
         end
         ST_REQ: begin
            M_request = 1'b1;
            if (OPB_MGrant) w_next = ST_XFER;
         end
         ST_XFER: begin
            // grant is not re-checked here; a granted master owns the cycle
            M_select = 1'b1;
            if (w_ev_err || w_ev_ack)  w_next = ST_RESP;
            else if (w_ev_retry)       w_next = w_retry_exh ? ST_RESP : ST_BACKOFF;
            else if (w_ev_tout)        w_next = ST_RESP;
         end
         ST_BACKOFF: begin
            w_next = ST_REQ;
         end
         ST_RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Command capture, retry/timeout counters and response registers
   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         r_rnw       <= 1'b0;
         r_addr      <= '0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_tout_cnt  <= '0;
         r_retry_cnt <= '0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_code  <= RSP_OK;
      end else begin
         if (r_state == ST_IDLE && cmd_valid) begin
            r_rnw       <= cmd_rnw;
            r_addr      <= cmd_addr;
            r_be        <= cmd_be;
            r_wdata     <= cmd_wdata;
            r_retry_cnt <= '0;
         end
         if (r_state == ST_RESP && rsp_ready) r_retry_cnt <= '0;

         // timeout counter restarts on every entry into the transfer phase
         if (r_state == ST_REQ && OPB_MGrant)
            r_tout_cnt <= '0;
         else if (w_in_xfer && !OPB_toutSup && r_tout_cnt != TOUT_MAX)
            r_tout_cnt <= r_tout_cnt + TW'(1);

         if (w_ev_retry && r_retry_cnt != RETRY_MAX)
            r_retry_cnt <= r_retry_cnt + RW'(1);

         if (w_ev_err) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_code  <= RSP_ERRACK;
         end else if (w_ev_ack) begin
            r_rsp_rdata <= r_rnw ? OPB_DBus : '0;
            r_rsp_err   <= 1'b0;
            r_rsp_code  <= RSP_OK;
         end else if (w_ev_retry && w_retry_exh) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_code  <= RSP_RETRY_EXH;
         end else if (w_ev_tout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_code  <= RSP_TIMEOUT;
         end
      end
   end

endmodule
